// File: rtl/bp_cce_pkg.sv
// Shared CCE definitions: pending-tracker sweep states and address-to-group helper.
`ifndef BP_CCE_PKG_SV
`define BP_CCE_PKG_SV

// Group index of an address: addr[lg(block size) +: lg(num groups)]
`define BP_CCE_PENDING_GROUP(addr, blk_lg, grp_lg) addr[(blk_lg) +: (grp_lg)]

package bp_cce_pkg;

    typedef enum logic {
        e_ready = 1'b0,
        e_clear = 1'b1
    } bp_cce_pending_state_e;

endpackage

`endif

// File: rtl/bp_cce_pending_cnt.sv
// One saturating up/down pending counter with clear; flags the cycles where an
// update would wrap past the top or below zero.
module bp_cce_pending_cnt
    import bp_cce_pkg::*;
#(
    parameter int cnt_width_p = 4
)
(
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   clr_i,
    input  logic                   inc_i,
    input  logic                   w_dec_i,
    input  logic                   m_dec_i,
    output logic [cnt_width_p-1:0] cnt_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam int ext_lp = cnt_width_p + 2;

    logic [cnt_width_p-1:0] cnt_r, cnt_n;
    logic [ext_lp-1:0]      up, down, diff, max_val;

    // Two guard bits so old + inc - decs never wraps during the range check.
    assign up      = {2'b00, cnt_r} + ext_lp'(inc_i);
    assign down    = ext_lp'(w_dec_i) + ext_lp'(m_dec_i);
    assign diff    = up - down;
    assign max_val = ext_lp'({cnt_width_p{1'b1}});

    always_comb begin
        cnt_n       = cnt_r;
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        if (clr_i) begin
            cnt_n = '0;
        end else if (up < down) begin
            cnt_n       = '0;
            underflow_o = 1'b1;
        end else if (diff > max_val) begin
            cnt_n      = cnt_r;
            overflow_o = 1'b1;
        end else begin
            cnt_n = cnt_width_p'(diff);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_n;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/bp_cce_pending_tracker.sv
// Per-group pending-transaction counters for the CCE: microcode WDP writes,
// memory-response auto-decrements, RDP lookup and a clear-all sweep.
module bp_cce_pending_tracker
    import bp_cce_pkg::*;
#(
    parameter int paddr_width_p         = 40,
    parameter int block_size_in_bytes_p = 64,
    parameter int num_groups_p          = 16,
    parameter int cnt_width_p           = 4
)
(
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     w_v_i,
    input  logic [paddr_width_p-1:0] w_addr_i,
    input  logic                     w_inc_i,
    input  logic                     w_clr_i,
    input  logic                     mem_resp_v_i,
    input  logic [paddr_width_p-1:0] mem_resp_addr_i,
    input  logic [paddr_width_p-1:0] r_addr_i,
    output logic                     pending_o,
    input  logic                     clear_all_i,
    output logic                     busy_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int blk_lg_lp = $clog2(block_size_in_bytes_p);
    localparam int grp_lg_lp = $clog2(num_groups_p);
    localparam logic [grp_lg_lp-1:0] last_idx_lp = grp_lg_lp'(num_groups_p - 1);

    logic [grp_lg_lp-1:0] w_grp, m_grp, r_grp, idx_r;
    logic [num_groups_p-1:0][cnt_width_p-1:0] cnt;
    logic [num_groups_p-1:0] ovf_evt, unf_evt;

    bp_cce_pending_state_e state_r;
    logic busy_r, ovf_r, unf_r;
    logic unused;

    assign w_grp = `BP_CCE_PENDING_GROUP(w_addr_i, blk_lg_lp, grp_lg_lp);
    assign m_grp = `BP_CCE_PENDING_GROUP(mem_resp_addr_i, blk_lg_lp, grp_lg_lp);
    assign r_grp = `BP_CCE_PENDING_GROUP(r_addr_i, blk_lg_lp, grp_lg_lp);
    assign unused = ^{w_addr_i, mem_resp_addr_i, r_addr_i};

    // Writes and responses are dropped during a sweep; the sweep owns the clears.
    for (genvar g = 0; g < num_groups_p; g++) begin : g_cnt
        logic hit_w, hit_m, sweep_clr;

        assign hit_w     = ~busy_r & w_v_i & (w_grp == grp_lg_lp'(g));
        assign hit_m     = ~busy_r & mem_resp_v_i & (m_grp == grp_lg_lp'(g));
        assign sweep_clr = busy_r & (idx_r == grp_lg_lp'(g));

        bp_cce_pending_cnt #(
            .cnt_width_p(cnt_width_p)
        ) u_cnt (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .clr_i       (sweep_clr | (hit_w & w_clr_i)),
            .inc_i       (hit_w & w_inc_i & ~w_clr_i),
            .w_dec_i     (hit_w & ~w_inc_i & ~w_clr_i),
            .m_dec_i     (hit_m),
            .cnt_o       (cnt[g]),
            .overflow_o  (ovf_evt[g]),
            .underflow_o (unf_evt[g])
        );
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_ready;
            idx_r   <= '0;
            busy_r  <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            case (state_r)
                e_ready: begin
                    if (|ovf_evt) ovf_r <= 1'b1;
                    if (|unf_evt) unf_r <= 1'b1;
                    if (clear_all_i) begin
                        state_r <= e_clear;
                        busy_r  <= 1'b1;
                        idx_r   <= '0;
                    end
                end
                e_clear: begin
                    idx_r <= idx_r + 1'b1;
                    if (idx_r == last_idx_lp) begin
                        state_r <= e_ready;
                        busy_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                        unf_r   <= 1'b0;
                    end
                end
                default: state_r <= e_ready;
            endcase
        end
    end

    // Report pending conservatively while counters are mid-sweep.
    assign pending_o   = busy_r | (cnt[r_grp] != '0);
    assign busy_o      = busy_r;
    assign overflow_o  = ovf_r;
    assign underflow_o = unf_r;

endmodule

// File: tb/tb_bp_cce_pending_tracker.sv
// Bench for bp_cce_pending_tracker: directed scenarios plus randomized traffic
// against an integer-array reference model of the pending counters.
module tb_bp_cce_pending_tracker;

    localparam int AW   = 40;
    localparam int NG   = 16;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          w_v, w_inc, w_clr, m_v, clear_all;
    logic [AW-1:0] w_addr, m_addr, r_addr;
    logic          pending, busy, ovf, unf;

    bp_cce_pending_tracker #(
        .paddr_width_p(AW),
        .block_size_in_bytes_p(64),
        .num_groups_p(NG),
        .cnt_width_p(4)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .w_v_i           (w_v),
        .w_addr_i        (w_addr),
        .w_inc_i         (w_inc),
        .w_clr_i         (w_clr),
        .mem_resp_v_i    (m_v),
        .mem_resp_addr_i (m_addr),
        .r_addr_i        (r_addr),
        .pending_o       (pending),
        .clear_all_i     (clear_all),
        .busy_o          (busy),
        .overflow_o      (ovf),
        .underflow_o     (unf)
    );

    always #50 clk = ~clk;

    int cnt_m [NG];
    bit sweeping;
    int sweep_left;
    bit ovf_m, unf_m;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int grp(input logic [AW-1:0] a);
        return int'((a / 64) % NG);
    endfunction

    function automatic logic [AW-1:0] mk_addr(input int g);
        logic [AW-1:0] a;
        a = {8'($urandom), 32'($urandom)};
        a = (a / 1024) * 1024 + AW'(g * 64) + AW'($urandom_range(63, 0));
        return a;
    endfunction

    function automatic bit exp_pending(input logic [AW-1:0] a);
        return sweeping || (cnt_m[grp(a)] != 0);
    endfunction

    task automatic model_reset();
        foreach (cnt_m[g]) cnt_m[g] = 0;
        sweeping   = 0;
        sweep_left = 0;
        ovf_m      = 0;
        unf_m      = 0;
    endtask

    task automatic model_step();
        int d, v;
        if (sweeping) begin
            cnt_m[NG - sweep_left] = 0;
            sweep_left--;
            if (sweep_left == 0) begin
                sweeping = 0;
                ovf_m    = 0;
                unf_m    = 0;
            end
        end else begin
            for (int g = 0; g < NG; g++) begin
                if (w_v && w_clr && grp(w_addr) == g) begin
                    cnt_m[g] = 0;
                end else begin
                    d = 0;
                    if (w_v && grp(w_addr) == g) d += (w_inc ? 1 : -1);
                    if (m_v && grp(m_addr) == g) d -= 1;
                    v = cnt_m[g] + d;
                    if (v < 0) begin
                        cnt_m[g] = 0;
                        unf_m    = 1;
                    end else if (v > CMAX) begin
                        cnt_m[g] = CMAX;
                        ovf_m    = 1;
                    end else begin
                        cnt_m[g] = v;
                    end
                end
            end
            if (clear_all) begin
                sweeping   = 1;
                sweep_left = NG;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, sweeping);
        check_eq({tag, "_pend"}, pending, exp_pending(r_addr));
        check_eq({tag, "_ovf"}, ovf, ovf_m);
        check_eq({tag, "_unf"}, unf, unf_m);
    endtask

    // One clock: drive at the falling edge, check mid-cycle, advance model at the rising edge.
    task automatic cycle(input string tag, input bit wv, input logic [AW-1:0] wa, input bit wi,
                         input bit wc, input bit mv, input logic [AW-1:0] ma,
                         input logic [AW-1:0] ra, input bit ca);
        @(negedge clk);
        w_v = wv; w_addr = wa; w_inc = wi; w_clr = wc;
        m_v = mv; m_addr = ma; r_addr = ra; clear_all = ca;
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, '0, 0, 0, 0, '0, mk_addr($urandom_range(NG-1, 0)), 0);
    endtask

    task automatic rand_cycle(input string tag, input bit allow_clear);
        cycle(tag, ($urandom % 3) != 0, mk_addr($urandom_range(3, 0)), ($urandom % 5) < 3,
              ($urandom % 16) == 0, ($urandom % 3) == 0, mk_addr($urandom_range(3, 0)),
              mk_addr($urandom_range(NG-1, 0)), allow_clear && (($urandom % 100) == 0));
    endtask

    task automatic check_all_pending(input string tag);
        @(negedge clk);
        w_v = 0; m_v = 0; clear_all = 0; w_clr = 0;
        for (int g = 0; g < NG; g++) begin
            r_addr = mk_addr(g);
            #1;
            check_eq({tag, "_grp", $sformatf("%0d", g)}, pending, exp_pending(r_addr));
        end
        @(posedge clk);
        model_step();
    endtask

    initial begin
        reset_n = 0;
        w_v = 0; w_addr = '0; w_inc = 0; w_clr = 0;
        m_v = 0; m_addr = '0; r_addr = '0; clear_all = 0;
        model_reset();
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_unf", unf, 0);
        check_eq("rst_pend", pending, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;

        // Increment then read two different groups.
        cycle("inc_g1", 1, 40'h1040, 1, 0, 0, '0, 40'h1040, 0);
        #10;
        r_addr = 40'h1040; #1; check_eq("rd_g1", pending, 1);
        r_addr = 40'h1080; #1; check_eq("rd_g2", pending, 0);

        // Same-cycle increment and response decrement on one group.
        cycle("incdec_g1", 1, 40'h1040, 1, 0, 1, 40'h1040, 40'h1040, 0);
        #10;
        r_addr = 40'h1040; #1; check_eq("incdec_hold", pending, 1);
        cycle("dec_g1", 1, 40'h1040, 0, 0, 0, '0, 40'h1040, 0);
        #10;
        check_eq("dec_g1_pend", pending, 0);
        check_eq("dec_g1_unf", unf, 0);

        // Saturation at 15 on group 3, then drain back to zero.
        repeat (15) cycle("sat_inc", 1, 40'h0C0, 1, 0, 0, '0, 40'h0C0, 0);
        #10;
        check_eq("sat_ovf_pre", ovf, 0);
        cycle("sat_inc16", 1, 40'h0C0, 1, 0, 0, '0, 40'h0C0, 0);
        #10;
        check_eq("sat_ovf", ovf, 1);
        repeat (14) cycle("sat_dec", 1, 40'h0C0, 0, 0, 0, '0, 40'h0C0, 0);
        #10;
        check_eq("sat_left1", pending, 1);
        cycle("sat_dec15", 1, 40'h0C0, 0, 0, 0, '0, 40'h0C0, 0);
        #10;
        check_eq("sat_empty", pending, 0);
        check_eq("sat_no_unf", unf, 0);

        // Double decrement from 1 underflows.
        cycle("unf_inc", 1, 40'h080, 1, 0, 0, '0, 40'h080, 0);
        cycle("unf_dd", 1, 40'h080, 0, 0, 1, 40'h080, 40'h080, 0);
        #10;
        check_eq("unf_pend", pending, 0);
        check_eq("unf_flag", unf, 1);

        // Sweep with traffic that must be ignored.
        cycle("sw_setup", 1, 40'h240, 1, 0, 0, '0, 40'h240, 0);
        cycle("sw_start", 0, '0, 0, 0, 0, '0, 40'h240, 1);
        repeat (NG) rand_cycle("sw_run", 1);
        #10;
        check_eq("sw_busy_done", busy, 0);
        check_eq("sw_ovf_clr", ovf, 0);
        check_eq("sw_unf_clr", unf, 0);
        check_all_pending("sw_after");

        // Reset in the fifth sweep cycle.
        cycle("rs_inc", 1, mk_addr(9), 1, 0, 0, '0, mk_addr(9), 0);
        cycle("rs_unf", 1, mk_addr(5), 0, 0, 0, '0, mk_addr(9), 0);
        cycle("rs_start", 0, '0, 0, 0, 0, '0, mk_addr(9), 1);
        repeat (4) idle("rs_sweep");
        @(negedge clk);
        #1;
        check_eq("rs_busy_pre", busy, 1);
        reset_n = 0;
        model_reset();
        #1;
        check_eq("rs_busy", busy, 0);
        check_eq("rs_ovf", ovf, 0);
        check_eq("rs_unf", unf, 0);
        for (int g = 0; g < NG; g++) begin
            r_addr = mk_addr(g);
            #1;
            check_eq($sformatf("rs_pend%0d", g), pending, 0);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        repeat (NG + 2) idle("rs_after");

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rand_cycle("rnd", 1);
            if (i % 100 == 99) check_all_pending("rnd_scan");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
